// File: rtl/jtbubl_shram_arb.sv
// Shared work RAM arbiter for the main and sub Z80s.
// Grants a single-port 8 KB RAM to one CPU at a time. Simultaneous requests
// are resolved by a toggling priority bit. Each CPU gets a registered read
// path and its own wait line. A saturating counter records contention.
// Ports:
//   clk24, rst_n                 clock and async active-low reset
//   cen                          CPU clock enable, qualifies RAM writes
//   main_* / sub_*               CPU select, write strobe, address, data
//   main_din / sub_din           registered read data back to each CPU
//   main_wait_n / sub_wait_n     combinational wait, active low
//   ram_addr/ram_data/ram_we     single-port RAM request
//   ram_q                        RAM read data, one clk24 after ram_addr
//   owner                        00 idle, 01 main, 10 sub
//   conflicts                    saturating count of contended cycles
module jtbubl_shram_arb #(
  parameter int unsigned AW   = 13,
  parameter int unsigned DW   = 8,
  parameter int unsigned CNTW = 8
) (
  input  logic            clk24,
  input  logic            rst_n,
  input  logic            cen,
  input  logic            main_cs,
  input  logic            main_wrn,
  input  logic [AW-1:0]   main_addr,
  input  logic [DW-1:0]   main_dout,
  output logic [DW-1:0]   main_din,
  output logic            main_wait_n,
  input  logic            sub_cs,
  input  logic            sub_wrn,
  input  logic [AW-1:0]   sub_addr,
  input  logic [DW-1:0]   sub_dout,
  output logic [DW-1:0]   sub_din,
  output logic            sub_wait_n,
  output logic [AW-1:0]   ram_addr,
  output logic [DW-1:0]   ram_data,
  output logic            ram_we,
  input  logic [DW-1:0]   ram_q,
  output logic [1:0]      owner,
  output logic [CNTW-1:0] conflicts
);

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_MAIN = 2'b01;
  localparam logic [1:0] ST_SUB  = 2'b10;

  logic [1:0] state, next_state;
  logic       prio, prio_nxt;   // 0: main wins a tie, 1: sub wins a tie
  logic       rdy;
  logic       owner_wrn;
  logic       conflict_c;

  // State, priority and read-ready registers
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      prio  <= 1'b0;
      rdy   <= 1'b0;
    end else begin
      state <= next_state;
      prio  <= prio_nxt;
      // ram_q follows the owner address one edge after the grant
      rdy   <= (next_state == state) && (state != ST_IDLE);
    end
  end

  // Ownership transitions
  always_comb begin
    next_state = state;
    prio_nxt   = prio;
    case (state)
      ST_IDLE: begin
        if (main_cs && sub_cs) begin
          next_state = prio ? ST_SUB : ST_MAIN;
          prio_nxt   = ~prio;
        end else if (main_cs) begin
          next_state = ST_MAIN;
        end else if (sub_cs) begin
          next_state = ST_SUB;
        end
      end
      ST_MAIN: begin
        if (!main_cs) next_state = sub_cs ? ST_SUB : ST_IDLE;
      end
      ST_SUB: begin
        if (!sub_cs) next_state = main_cs ? ST_MAIN : ST_IDLE;
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // RAM request mux; idle defaults to the main CPU side
  always_comb begin
    ram_addr  = main_addr;
    ram_data  = main_dout;
    owner_wrn = main_wrn;
    if (state == ST_SUB) begin
      ram_addr  = sub_addr;
      ram_data  = sub_dout;
      owner_wrn = sub_wrn;
    end
  end

  assign ram_we = (state != ST_IDLE) && !owner_wrn && rdy && cen;

  // Waits are gated by rst_n so a reset releases both CPUs at once
  assign main_wait_n = !(rst_n && main_cs && ((state != ST_MAIN) || !rdy));
  assign sub_wait_n  = !(rst_n && sub_cs  && ((state != ST_SUB)  || !rdy));

  assign owner = state;

  // A CPU held off because the other one owns the RAM
  assign conflict_c = (main_cs && (state == ST_SUB)) ||
                      (sub_cs  && (state == ST_MAIN));

  // Read data return paths
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      main_din <= DW'(0);
      sub_din  <= DW'(0);
    end else if (rdy) begin
      if (state == ST_MAIN) main_din <= ram_q;
      if (state == ST_SUB)  sub_din  <= ram_q;
    end
  end

  // Saturating contention counter
  always_ff @(posedge clk24 or negedge rst_n) begin
    if (!rst_n) begin
      conflicts <= CNTW'(0);
    end else if (conflict_c && (conflicts != {CNTW{1'b1}})) begin
      conflicts <= conflicts + CNTW'(1);
    end
  end

endmodule

// File: tb/tb_jtbubl_shram_arb.sv
// Bench for jtbubl_shram_arb: behavioural RAM, an ownership model checked
// every clk24, and directed scenarios with hand-computed expectations.
module tb_jtbubl_shram_arb;

  localparam int unsigned AW   = 13;
  localparam int unsigned DW   = 8;
  localparam int unsigned CNTW = 8;

  logic            clk24 = 1'b0;
  logic            rst_n = 1'b1;
  logic            cen = 1'b0;
  logic            main_cs = 1'b0, main_wrn = 1'b1;
  logic [AW-1:0]   main_addr = '0;
  logic [DW-1:0]   main_dout = '0;
  logic [DW-1:0]   main_din;
  logic            main_wait_n;
  logic            sub_cs = 1'b0, sub_wrn = 1'b1;
  logic [AW-1:0]   sub_addr = '0;
  logic [DW-1:0]   sub_dout = '0;
  logic [DW-1:0]   sub_din;
  logic            sub_wait_n;
  logic [AW-1:0]   ram_addr;
  logic [DW-1:0]   ram_data;
  logic            ram_we;
  logic [DW-1:0]   ram_q = '0;
  logic [1:0]      owner;
  logic [CNTW-1:0] conflicts;

  int n_tests = 0;
  int n_fail  = 0;

  jtbubl_shram_arb #(.AW(AW), .DW(DW), .CNTW(CNTW)) dut (
    .clk24(clk24), .rst_n(rst_n), .cen(cen),
    .main_cs(main_cs), .main_wrn(main_wrn), .main_addr(main_addr),
    .main_dout(main_dout), .main_din(main_din), .main_wait_n(main_wait_n),
    .sub_cs(sub_cs), .sub_wrn(sub_wrn), .sub_addr(sub_addr),
    .sub_dout(sub_dout), .sub_din(sub_din), .sub_wait_n(sub_wait_n),
    .ram_addr(ram_addr), .ram_data(ram_data), .ram_we(ram_we), .ram_q(ram_q),
    .owner(owner), .conflicts(conflicts)
  );

  always #5 clk24 = ~clk24;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // cen6-like strobe: one clk24 in four, or forced high
  bit cen_force = 1'b0;
  int cyc = 0;
  always @(negedge clk24) begin
    cyc++;
    cen = cen_force || (cyc % 4 == 0);
  end

  // Behavioural single-port RAM, read-before-write, registered output
  logic [DW-1:0] mem [0:8191];
  int we_cnt = 0, we_bad = 0;
  always @(posedge clk24) begin
    ram_q <= mem[ram_addr];
    if (ram_we) begin
      mem[ram_addr] <= ram_data;
      we_cnt++;
      if (!cen) we_bad++;
    end
  end

  // Ownership model: who owns the RAM and how many edges since the grant
  int            own_m = 0;     // 0 idle, 1 main, 2 sub
  int            age_m = 0;
  bit            sub_first_m = 1'b0;
  int            cnt_m = 0;
  logic [DW-1:0] mem_m [0:8191];
  logic [DW-1:0] q_m = '0, mdin_m = '0, sdin_m = '0;

  function automatic logic [AW-1:0] addr_m();
    return (own_m == 2) ? sub_addr : main_addr;
  endfunction

  function automatic bit ready_m();
    return (own_m != 0) && (age_m >= 1);
  endfunction

  function automatic bit we_m();
    bit wrn;
    wrn = (own_m == 2) ? sub_wrn : main_wrn;
    return rst_n && ready_m() && cen && !wrn;
  endfunction

  always @(posedge clk24) begin
    int nxt;
    logic [AW-1:0] a;
    a = addr_m();
    if (!rst_n) begin
      q_m = mem_m[a];
      own_m = 0; age_m = 0; sub_first_m = 1'b0; cnt_m = 0;
      mdin_m = '0; sdin_m = '0;
    end else begin
      if (ready_m()) begin
        if (own_m == 1) mdin_m = q_m;
        else            sdin_m = q_m;
      end
      if (we_m()) begin
        q_m = mem_m[a];
        mem_m[a] = (own_m == 2) ? sub_dout : main_dout;
      end else begin
        q_m = mem_m[a];
      end
      if (((main_cs && own_m == 2) || (sub_cs && own_m == 1)) && cnt_m < 255) cnt_m++;
      nxt = own_m;
      if (own_m == 0) begin
        if (main_cs && sub_cs) begin
          nxt = sub_first_m ? 2 : 1;
          sub_first_m = !sub_first_m;
        end else if (main_cs) nxt = 1;
        else if (sub_cs) nxt = 2;
      end else if (own_m == 1) begin
        if (!main_cs) nxt = sub_cs ? 2 : 0;
      end else begin
        if (!sub_cs) nxt = main_cs ? 1 : 0;
      end
      if (nxt != own_m) age_m = 0;
      else if (age_m < 2) age_m++;
      own_m = nxt;
    end
    #2;
    check("owner", 32'(owner), 32'(own_m));
    check("ram_we", 32'(ram_we), 32'(we_m()));
    check("ram_addr", 32'(ram_addr), 32'(addr_m()));
    check("main_wait_n", 32'(main_wait_n),
          32'(!(rst_n && main_cs && (own_m != 1 || !ready_m()))));
    check("sub_wait_n", 32'(sub_wait_n),
          32'(!(rst_n && sub_cs && (own_m != 2 || !ready_m()))));
    check("main_din", 32'(main_din), 32'(mdin_m));
    check("sub_din", 32'(sub_din), 32'(sdin_m));
    check("conflicts", 32'(conflicts), 32'(cnt_m));
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk24);
  endtask

  // Edges until the CPU's wait releases; also pins the owner after the first edge
  task automatic measure(input bit is_main, input int first_owner, output int n);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk24); #3;
      n++;
      if (n == 1) check("owner_after_grant", 32'(owner), 32'(first_owner));
      if ((is_main ? main_wait_n : sub_wait_n) == 1'b1) break;
    end
  endtask

  initial begin
    int n;
    int c0;
    bit seen;
    for (int i = 0; i < 8192; i++) begin
      mem[i]   = 8'(i ^ (i >> 8));
      mem_m[i] = 8'(i ^ (i >> 8));
    end
    mem[13'h0123]   = 8'h5A;
    mem_m[13'h0123] = 8'h5A;
    #1 rst_n = 1'b0;
    #11;
    check("rst_owner", 32'(owner), 32'h0);
    check("rst_ram_we", 32'(ram_we), 32'h0);
    check("rst_conflicts", 32'(conflicts), 32'h0);
    check("rst_main_din", 32'(main_din), 32'h0);
    @(negedge clk24) rst_n = 1'b1;
    tick(1);

    // Uncontended read by main
    main_addr = 13'h0123; main_wrn = 1'b1; main_cs = 1'b1;
    #1 check("t1_wait_low", 32'(main_wait_n), 32'h0);
    measure(1'b1, 1, n);
    check("t1_wait_edges", 32'(n), 32'd2);
    tick(2);
    check("t1_main_din", 32'(main_din), 32'h5A);
    check("t1_conflicts", 32'(conflicts), 32'h0);
    main_cs = 1'b0;
    tick(2);

    // Simultaneous requests: main first, then handover without idle
    main_addr = 13'h0010; sub_addr = 13'h0200;
    main_cs = 1'b1; sub_cs = 1'b1;
    @(posedge clk24); #3;
    check("t2_first_main", 32'(owner), 32'h1);
    check("t2_sub_held", 32'(sub_wait_n), 32'h0);
    tick(3);
    main_cs = 1'b0;
    measure(1'b0, 2, n);
    check("t4_sub_wait_edges", 32'(n), 32'd2);
    tick(2);
    sub_cs = 1'b0;
    tick(2);
    main_cs = 1'b1; sub_cs = 1'b1;
    @(posedge clk24); #3;
    check("t2_second_sub", 32'(owner), 32'h2);
    tick(3);
    main_cs = 1'b0; sub_cs = 1'b0;
    tick(2);

    // Main writes 0xA5 to 0x1FFF while sub waits on the same address
    we_cnt = 0; we_bad = 0;
    main_addr = 13'h1FFF; main_dout = 8'hA5; main_wrn = 1'b0; main_cs = 1'b1;
    tick(1);
    c0 = cnt_m;
    sub_addr = 13'h1FFF; sub_cs = 1'b1;
    tick(6);
    main_cs = 1'b0; main_wrn = 1'b1;
    tick(4);
    check("t3_we_pulsed", 32'(we_cnt > 0), 32'h1);
    check("t3_we_without_cen", 32'(we_bad), 32'h0);
    check("t3_sub_din", 32'(sub_din), 32'hA5);
    check("t3_conflicts", 32'(conflicts), 32'(c0 + 7));
    sub_cs = 1'b0;
    tick(3);

    // Long contention saturates the counter
    main_addr = 13'h0000; main_cs = 1'b1;
    tick(1);
    sub_cs = 1'b1;
    tick(300);
    check("t5_saturated", 32'(conflicts), 32'hFF);
    main_cs = 1'b0; sub_cs = 1'b0;
    tick(3);

    // Reset asserted mid-write
    cen_force = 1'b1;
    main_addr = 13'h0042; main_dout = 8'h3C; main_wrn = 1'b0;
    main_cs = 1'b1; sub_cs = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      @(posedge clk24); #3;
      seen = ram_we;
    end
    check("t6_write_active", 32'(seen), 32'h1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_ram_we", 32'(ram_we), 32'h0);
    check("t6_owner", 32'(owner), 32'h0);
    check("t6_main_wait_n", 32'(main_wait_n), 32'h1);
    check("t6_sub_wait_n", 32'(sub_wait_n), 32'h1);
    check("t6_conflicts", 32'(conflicts), 32'h0);
    main_cs = 1'b0; sub_cs = 1'b0; main_wrn = 1'b1;
    tick(2);
    rst_n = 1'b1;
    cen_force = 1'b0;
    tick(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
